// File: rtl/sonic_pkg.sv
// Shared definitions for the ultrasonic range-finder controller.
//   state_t   : measurement FSM states
//   DIST_NONE : distance word meaning "no echo / out of range"
//   DIST_MAX  : largest real distance; the accumulator saturates here
//   cnt_w()   : width of a counter that must hold 0..n-1
package sonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [19:0] DIST_NONE = 20'hFFFFF;
  localparam logic [19:0] DIST_MAX  = 20'hFFFFE;

  // $clog2(n) bits hold n-1; keep at least one bit for tiny parameters.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sonic_ranger_echo_sync.sv
// echo_sync: brings the asynchronous sensor echo into the clk domain.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   echo : raw echo pin (asynchronous)
//   rise : one-cycle pulse, registered, after a synchronized 0->1 transition
//   fall : one-cycle pulse, registered, after a synchronized 1->0 transition
// The synchronized level lags the pin by 2 cycles; the edge pulses appear
// in the cycle after that.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_1    <= echo;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      rise      <= sync_2 & ~sync_prev;
      fall      <= ~sync_2 & sync_prev;
    end
  end

endmodule

// File: rtl/sonic_ranger.sv
// sonic_ranger: HC-SR04-style ultrasonic range-finder controller.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   en        : measurement enable; low keeps the block idle between runs
//   echo      : sensor echo pin (asynchronous)
//   trig      : sensor trigger pulse, TRIG_CYC cycles wide
//   distance  : last result in mm, DIST_NONE when no echo / out of range
//   valid     : one-cycle strobe when distance is written
//   timeout   : set by a timed-out measurement, cleared by a good one
//   dbg_state : current FSM state, for observation only
// Echo width is converted to mm by a modulo-CYC_PER_MM sub-counter that
// bumps a saturating accumulator on every wrap, so no divider is needed.
module sonic_ranger
  import sonic_pkg::*;
#(
  parameter int TRIG_CYC    = 1000,
  parameter int PERIOD_CYC  = 6_000_000,
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int CYC_PER_MM  = 580
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [19:0] distance,
  output logic        valid,
  output logic        timeout,
  output state_t      dbg_state
);

  localparam int TRIG_W = cnt_w(TRIG_CYC);
  localparam int PER_W  = cnt_w(PERIOD_CYC);
  localparam int TO_W   = cnt_w(TIMEOUT_CYC);
  localparam int MM_W   = cnt_w(CYC_PER_MM);

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYC - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [MM_W-1:0]   MM_LAST   = MM_W'(CYC_PER_MM - 1);

  state_t state;
  state_t next_state;

  logic echo_rise;
  logic echo_fall;

  logic [PER_W-1:0]  per_cnt;
  logic [TRIG_W-1:0] trig_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [MM_W-1:0]   mm_cnt;
  logic [19:0]       acc;

  logic        to_hit;
  logic        mm_wrap;
  logic [19:0] acc_next;

  echo_sync u_echo_sync (
    .clk  (clk),
    .rst  (rst),
    .echo (echo),
    .rise (echo_rise),
    .fall (echo_fall)
  );

  assign to_hit   = ((state == WAIT_ECHO) || (state == MEASURE)) && (to_cnt == TO_LAST);
  assign mm_wrap  = (mm_cnt == MM_LAST);
  // Value the accumulator takes at the end of this MEASURE cycle; the final
  // cycle of the echo must be included in the published result.
  assign acc_next = (mm_wrap && (acc != DIST_MAX)) ? acc + 20'd1 : acc;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  // Timeout takes priority over an echo edge arriving in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (en && (per_cnt >= PER_LAST)) next_state = TRIG;
      TRIG:      if (trig_cnt == TRIG_LAST)       next_state = WAIT_ECHO;
      WAIT_ECHO: if (to_hit)                      next_state = IDLE;
                 else if (echo_rise)              next_state = MEASURE;
      MEASURE:   if (to_hit)                      next_state = IDLE;
                 else if (echo_fall)              next_state = DONE;
      DONE:                                       next_state = IDLE;
      default:                                    next_state = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // trig is decoded from the state so an async reset drops it instantly.
  always_comb begin
    trig      = (state == TRIG);
    dbg_state = state;
  end

  // ---------------- counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt  <= '0;
      trig_cnt <= '0;
      to_cnt   <= '0;
      mm_cnt   <= '0;
      acc      <= '0;
    end else begin
      // Free-running period counter, restarted at each trigger start.
      if ((state == IDLE) && (next_state == TRIG)) per_cnt <= '0;
      else if (per_cnt != PER_LAST)                per_cnt <= per_cnt + 1'b1;

      if ((state == TRIG) && (trig_cnt != TRIG_LAST)) trig_cnt <= trig_cnt + 1'b1;
      else                                            trig_cnt <= '0;

      // Zero outside WAIT_ECHO/MEASURE, so it starts from 0 when TRIG ends.
      if ((state == WAIT_ECHO) || (state == MEASURE)) to_cnt <= to_cnt + 1'b1;
      else                                            to_cnt <= '0;

      if (state == WAIT_ECHO) begin
        mm_cnt <= '0;
        acc    <= '0;
      end else if (state == MEASURE) begin
        mm_cnt <= mm_wrap ? '0 : mm_cnt + 1'b1;
        acc    <= acc_next;
      end
    end
  end

  // ---------------- result registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      distance <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (to_hit) begin
        distance <= DIST_NONE;
        timeout  <= 1'b1;
        valid    <= 1'b1;
      end else if ((state == MEASURE) && (next_state == DONE)) begin
        distance <= acc_next;
        timeout  <= 1'b0;
        valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sonic_ranger.sv
// Directed bench for sonic_ranger with TRIG_CYC=4, PERIOD_CYC=200,
// TIMEOUT_CYC=150, CYC_PER_MM=10.
module tb_sonic_ranger;
  import sonic_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        echo;
  logic        trig;
  logic [19:0] distance;
  logic        valid;
  logic        timeout;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  bit seen_trig_echo_high = 0;

  sonic_ranger #(
    .TRIG_CYC    (4),
    .PERIOD_CYC  (200),
    .TIMEOUT_CYC (150),
    .CYC_PER_MM  (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .echo      (echo),
    .trig      (trig),
    .distance  (distance),
    .valid     (valid),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // valid strobes, sampled on the falling edge
  always @(negedge clk) if (valid === 1'b1) valid_cnt++;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of steps until valid is seen, or -1 if the limit expires.
  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Waits for the next trigger pulse and returns in its first low cycle.
  task automatic wait_trig_fall(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (trig === 1'b1) begin ok = 1; break; end
      step();
    end
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (trig === 1'b0) begin ok = 1; break; end
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_trig_wait: trigger pulse not seen within bound", name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int  n;
    int  w;
    bit  bad_v;
    bit  bad_d;
    rst  = 1'b0;
    en   = 1'b1;
    echo = 1'b0;
    repeat (3) step();
    checks++; if (trig !== 1'b0)     begin errors++; $display("FAIL reset_trig: got %b want 0", trig); end
    checks++; if (distance !== 20'd0) begin errors++; $display("FAIL reset_distance: got %h want 0", distance); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (timeout !== 1'b0)  begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end

    rst   = 1'b1;
    n     = -1;
    bad_v = 0;
    bad_d = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (trig === 1'b1) begin n = i; break; end
      if (valid !== 1'b0) bad_v = 1;
      if (distance !== 20'd0) bad_d = 1;
    end
    checks++; if (n != 200) begin errors++; $display("FAIL first_trig_cycle: got %0d want 200", n); end
    checks++; if (bad_v)    begin errors++; $display("FAIL pre_trig_valid: valid pulsed, want none"); end
    checks++; if (bad_d)    begin errors++; $display("FAIL pre_trig_distance: distance changed, want 0"); end

    w = 0;
    for (int i = 0; i < 20; i++) begin
      if (trig !== 1'b1) break;
      w++;
      step();
    end
    checks++; if (w != 4) begin errors++; $display("FAIL trig_width: got %0d want 4", w); end
  endtask

  // Continues straight from test_reset: trigger has just fallen.
  task automatic test_basic_measure();
    int n;
    int vc0;
    vc0 = valid_cnt;
    repeat (5) step();
    echo = 1'b1;
    repeat (123) step();
    echo = 1'b0;
    wait_valid(20, n);
    checks++; if (n != 4)            begin errors++; $display("FAIL basic_latency: got %0d want 4", n); end
    checks++; if (distance !== 20'd12) begin errors++; $display("FAIL basic_distance: got %0d want 12", distance); end
    checks++; if (timeout !== 1'b0)  begin errors++; $display("FAIL basic_timeout: got %b want 0", timeout); end
    step();
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL basic_valid_width: got %b want 0", valid); end
    checks++; if (valid_cnt - vc0 != 1) begin errors++; $display("FAIL basic_valid_count: got %0d want 1", valid_cnt - vc0); end
  endtask

  task automatic test_no_echo();
    int n;
    wait_trig_fall("no_echo");
    wait_valid(300, n);
    checks++; if (n != 150)               begin errors++; $display("FAIL no_echo_latency: got %0d want 150", n); end
    checks++; if (distance !== 20'hFFFFF) begin errors++; $display("FAIL no_echo_distance: got %h want fffff", distance); end
    checks++; if (timeout !== 1'b1)       begin errors++; $display("FAIL no_echo_timeout: got %b want 1", timeout); end

    wait_trig_fall("recover");
    checks++; if (timeout !== 1'b1)       begin errors++; $display("FAIL timeout_sticky: got %b want 1", timeout); end
    repeat (5) step();
    echo = 1'b1;
    repeat (50) step();
    echo = 1'b0;
    wait_valid(20, n);
    checks++; if (n != 4)                 begin errors++; $display("FAIL recover_latency: got %0d want 4", n); end
    checks++; if (distance !== 20'd5)     begin errors++; $display("FAIL recover_distance: got %0d want 5", distance); end
    checks++; if (timeout !== 1'b0)       begin errors++; $display("FAIL recover_timeout: got %b want 0", timeout); end
  endtask

  // Echo held 200 cycles: times out in MEASURE; the next trigger fires while
  // echo is still high, which sets up test_echo_already_high.
  task automatic test_measure_timeout();
    int n;
    wait_trig_fall("meas_timeout");
    repeat (5) step();
    echo = 1'b1;
    n = -1;
    seen_trig_echo_high = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if ((valid === 1'b1) && (n < 0)) n = i;
      if (trig === 1'b1) seen_trig_echo_high = 1;
    end
    echo = 1'b0;
    checks++; if (n != 145)               begin errors++; $display("FAIL meas_timeout_latency: got %0d want 145", n); end
    checks++; if (distance !== 20'hFFFFF) begin errors++; $display("FAIL meas_timeout_distance: got %h want fffff", distance); end
    checks++; if (timeout !== 1'b1)       begin errors++; $display("FAIL meas_timeout_flag: got %b want 1", timeout); end
  endtask

  task automatic test_echo_already_high();
    int n;
    int vc0;
    checks++; if (seen_trig_echo_high != 1) begin errors++; $display("FAIL high_trig_seen: got %0d want 1", seen_trig_echo_high); end
    vc0 = valid_cnt;
    repeat (10) step();
    echo = 1'b1;
    repeat (30) step();
    echo = 1'b0;
    wait_valid(20, n);
    checks++; if (valid_cnt != vc0)   begin errors++; $display("FAIL high_spurious_valid: got %0d want 0", valid_cnt - vc0); end
    checks++; if (n != 4)             begin errors++; $display("FAIL high_latency: got %0d want 4", n); end
    checks++; if (distance !== 20'd3) begin errors++; $display("FAIL high_distance: got %0d want 3", distance); end
    checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL high_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_en_drop();
    int n;
    int vc0;
    bit trig_seen;
    wait_trig_fall("en_drop");
    repeat (5) step();
    echo = 1'b1;
    repeat (15) step();
    en = 1'b0;
    repeat (25) step();
    echo = 1'b0;
    wait_valid(20, n);
    checks++; if (n != 4)             begin errors++; $display("FAIL en_drop_latency: got %0d want 4", n); end
    checks++; if (distance !== 20'd4) begin errors++; $display("FAIL en_drop_distance: got %0d want 4", distance); end
    step();
    vc0 = valid_cnt;
    trig_seen = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (trig !== 1'b0) trig_seen = 1;
    end
    checks++; if (trig_seen != 0)     begin errors++; $display("FAIL en_drop_trig: got trig, want none"); end
    checks++; if (valid_cnt != vc0)   begin errors++; $display("FAIL en_drop_valid: got %0d pulses want 0", valid_cnt - vc0); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int vc0;
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (trig === 1'b1) begin ok = 1; break; end
      step();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_trig_wait: trig not seen after en restored"); end
    #2 rst = 1'b0;
    #1;
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL rst_trig_drop: got %b want 0", trig); end
    step();
    rst = 1'b1;

    wait_trig_fall("rst_mid");
    repeat (5) step();
    echo = 1'b1;
    repeat (20) step();
    #2 rst = 1'b0;
    #1;
    checks++; if (trig !== 1'b0)      begin errors++; $display("FAIL rst_mid_trig: got %b want 0", trig); end
    checks++; if (distance !== 20'd0) begin errors++; $display("FAIL rst_mid_distance: got %0d want 0", distance); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL rst_mid_valid: got %b want 0", valid); end
    checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL rst_mid_timeout: got %b want 0", timeout); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d want IDLE", dbg_state); end
    step();
    step();
    rst = 1'b1;
    vc0 = valid_cnt;
    repeat (30) step();
    echo = 1'b0;
    repeat (150) step();
    checks++; if (valid_cnt != vc0)   begin errors++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", valid_cnt - vc0); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    echo = 1'b0;
    test_reset();
    test_basic_measure();
    test_no_echo();
    test_measure_timeout();
    test_echo_already_high();
    test_en_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonic_ranger.md
# sonic_ranger

Ultrasonic range-finder controller for the HC-SR04-style sensor. It periodically fires a trigger pulse and times the returned echo. It converts the echo width to millimetres without a divider and publishes a 20-bit distance word. It sits directly upstream of the distance seven-segment display driver, whose `distance` input it feeds, and of any obstacle-avoidance logic sharing that bus.

## Interface
- `TRIG_CYC`, 1000: trigger pulse width in clk cycles (10 µs at 100 MHz).
- `PERIOD_CYC`, 6_000_000: minimum start-to-start spacing of measurements (60 ms).
- `TIMEOUT_CYC`, 2_500_000: maximum cycles from trigger end to echo fall (25 ms).
- `CYC_PER_MM`, 580: echo-high cycles per millimetre of range.

- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `en` input 1: measurement enable; low holds the block idle.
- `echo` input 1: sensor echo, asynchronous to clk.
- `trig` output 1: sensor trigger pulse.
- `distance` output 20: last result in mm; 20'hFFFFF = no echo / out of range.
- `valid` output 1: one-cycle strobe when `distance` updates.
- `timeout` output 1: sticky-per-measurement flag, set when the last measurement timed out.

## Operation
- `echo` passes through a 2-flop synchronizer and then a rising/falling edge detector. All decisions use the synchronized signal.
- States:
  - IDLE: `trig` = 0. Go to TRIG when `en` = 1 and the period counter ≥ PERIOD_CYC−1.
  - TRIG: `trig` = 1 for exactly TRIG_CYC cycles. The period counter clears on entry. Then go to WAIT_ECHO.
  - WAIT_ECHO: wait for a synchronized rising edge, then go to MEASURE. If `echo` is already high on entry, that does not count; only a 0→1 edge starts MEASURE.
  - MEASURE: count echo-high time. On a falling edge, go to DONE.
  - DONE: one cycle. Update `distance`, pulse `valid`, return to IDLE.
- Timeout counter:
  - Clears on TRIG exit and runs through WAIT_ECHO and MEASURE.
  - On reaching TIMEOUT_CYC−1 in either state: `distance` ← 20'hFFFFF, `timeout` ← 1, `valid` pulses, and the state goes to IDLE.
- Conversion: a sub-counter counts 0..CYC_PER_MM−1 while in MEASURE. On each wrap, a 20-bit accumulator increments, saturating at 20'hFFFFE. The result is floor(high_cycles / CYC_PER_MM).
- Counters:
  - The period counter is free-running and saturates at PERIOD_CYC−1.
  - Start-to-start spacing is max(PERIOD_CYC, measurement length).
- `en` deasserted mid-measurement: the current measurement completes normally, then the block stays in IDLE.
- A successful measurement clears `timeout`. `distance` holds between updates.

## Timing
- Reset values: `trig` 0, `distance` 0, `valid` 0, `timeout` 0, state IDLE, all counters 0.
- Reset asserted mid-measurement: all of the above apply immediately and asynchronously; `trig` drops the same instant.
- First trigger: `trig` rises on the edge after the period counter reaches PERIOD_CYC−1, provided `en` = 1.
- Echo latency: synchronized `echo` lags the pin by 2 cycles. The edge is detected in the following cycle.
- Result latency: `valid` and the new `distance` appear together exactly 1 cycle after the falling edge is detected (DONE cycle), which is 4 cycles after the raw `echo` falls.
- Timeout latency: `valid` and `timeout` rise the cycle after the timeout counter reaches TIMEOUT_CYC−1.
- Echo pulses shorter than 2 cycles may be missed; this is acceptable.

## Structure
- Shared package `sonic_pkg`:
  - state enum (IDLE, TRIG, WAIT_ECHO, MEASURE, DONE);
  - `DIST_NONE` = 20'hFFFFF;
  - `DIST_MAX` = 20'hFFFFE;
  - counter-width helpers ($clog2 of each parameter).
- One sub-module, `echo_sync`: 2-flop synchronizer plus rise/fall pulse outputs, with its own async active-low reset.
- FSM, counters and conversion stay in `sonic_ranger`.

## Test plan
Benches use TRIG_CYC=4, PERIOD_CYC=200, TIMEOUT_CYC=150, CYC_PER_MM=10.
- Reset release with `en`=1 → `trig` high for exactly 4 cycles starting at cycle 200; `distance`=0 and `valid`=0 before that.
- Echo rises 5 cycles after `trig` falls and stays high 123 cycles → one `valid` pulse, `distance`=12, `timeout`=0.
- No echo → `valid` pulses 150 cycles after `trig` falls, `distance`=20'hFFFFF, `timeout`=1. The next good echo of 50 cycles gives `distance`=5 and `timeout`=0.
- Echo high for 200 cycles → timeout in MEASURE: `distance`=20'hFFFFF and `timeout`=1.
- Echo already high when `trig` ends, then falls, then rises for 30 cycles → the measurement starts only on the new rise; `distance`=3.
- `en` dropped during MEASURE → the result still posts and no further `trig` is issued. Separately, `rst` asserted mid-MEASURE → all outputs are 0 at once, and `valid` does not pulse after release until a new measurement.
